// File: rtl/io_latch_pkg.sv
// io_latch_pkg: register map helpers and field positions shared by the
// io_latch_bank top and its bench-facing decode logic.
package io_latch_pkg;

   // Kind of register selected by a local bus address
   typedef enum logic [1:0] {
      ACC_NONE   = 2'd0,
      ACC_DATA   = 2'd1,
      ACC_STATUS = 2'd2,
      ACC_CTRL   = 2'd3
   } regKind_t;

   // Channel data registers start at offset 0
   function automatic int dataBase();
      return 0;
   endfunction

   // STATUS sits directly after the last data register
   function automatic int statusAddr(input int channels);
      return channels;
   endfunction

   // CTRL follows STATUS
   function automatic int ctrlAddr(input int channels);
      return channels + 1;
   endfunction

   // STATUS layout: ibf in the low CHANNELS bits, ovr in the next CHANNELS
   function automatic int ibfLsb();
      return 0;
   endfunction

   function automatic int ovrLsb(input int channels);
      return channels;
   endfunction

   // CTRL layout: dir in the low CHANNELS bits, irq_en in the next CHANNELS
   function automatic int dirLsb();
      return 0;
   endfunction

   function automatic int irqEnLsb(input int channels);
      return channels;
   endfunction

   // Both STATUS and CTRL must fit two CHANNELS-wide fields in one data word
   function automatic bit paramsLegal(input int width, input int channels);
      return (channels >= 2) && (2 * channels <= width);
   endfunction

   // Classify a local address into the register it selects
   function automatic regKind_t decodeAddr(input int a, input int channels);
      if (a >= dataBase() && a < dataBase() + channels) return ACC_DATA;
      if (a == statusAddr(channels))                    return ACC_STATUS;
      if (a == ctrlAddr(channels))                      return ACC_CTRL;
      return ACC_NONE;
   endfunction

endpackage

// File: rtl/io_latch_bank_sync_edge.sv
// sync_edge: two-flop synchroniser for an asynchronous level plus an edge
// flop producing one-cycle rise/fall pulses. After reset the pulses stay
// disarmed until the synchronised input has been seen at its idle level, so
// a strobe held active through reset never produces an edge on release.
module sync_edge #(
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst_h,
   input  logic i_async,
   output logic o_rise,
   output logic o_fall
);

   logic       r_meta;
   logic       r_sync;
   logic       r_prev;
   logic [1:0] r_live;
   logic       r_armed;

   // Synchronise the input, track its previous value and arm once idle is seen
   always_ff @(posedge clk) begin
      if (rst_h) begin
         r_meta  <= IDLE_LEVEL;
         r_sync  <= IDLE_LEVEL;
         r_prev  <= IDLE_LEVEL;
         r_live  <= 2'b00;
         r_armed <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_live <= {r_live[0], 1'b1};
         if (r_live[1] && (r_sync == IDLE_LEVEL)) begin
            r_armed <= 1'b1;
         end
      end
   end

   assign o_rise = r_armed &  r_sync & ~r_prev;
   assign o_fall = r_armed & ~r_sync &  r_prev;

endmodule

// File: rtl/io_latch_bank.sv
// io_latch_bank: CHANNELS bidirectional latch ports behind a small CPU
// register file. Output channels drive the CPU-written value onto their pins;
// input channels capture their pins on a peripheral strobe and flag it.
module io_latch_bank
   import io_latch_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int AW       = $clog2(CHANNELS) + 1
) (
   input  logic                        clk,
   input  logic                        rst_h,
   input  logic                        cs_l,
   input  logic                        rd_l,
   input  logic                        wr_l,
   input  logic [AW-1:0]               addr,
   input  logic [WIDTH-1:0]            din,
   output logic [WIDTH-1:0]            dout,
   output logic                        dout_oe_l,
   input  logic [CHANNELS*WIDTH-1:0]   pin_in,
   output logic [CHANNELS*WIDTH-1:0]   pin_out,
   output logic [CHANNELS-1:0]         pin_oe_l,
   input  logic [CHANNELS-1:0]         stb_l,
   output logic [CHANNELS-1:0]         ibf,
   output logic                        irq_l
);

   localparam bit PARAMS_OK = paramsLegal(WIDTH, CHANNELS);

   if (!PARAMS_OK) begin : gBadParams
      $error("io_latch_bank: need CHANNELS >= 2 and 2*CHANNELS <= WIDTH");
   end

   logic [CHANNELS-1:0][WIDTH-1:0] r_data;
   logic [CHANNELS-1:0]            r_dir;
   logic [CHANNELS-1:0]            r_irqEn;
   logic [CHANNELS-1:0]            r_ibf;
   logic [CHANNELS-1:0]            r_ovr;
   logic [AW-1:0]                  r_rdAddr;

   logic                w_wrAct;
   logic                w_rdAct;
   logic                w_wrRise;
   logic                w_wrFallUnused;
   logic                w_rdRise;
   logic                w_rdFall;
   logic [CHANNELS-1:0] w_stbFall;
   logic [CHANNELS-1:0] w_stbRiseUnused;

   regKind_t            w_wrKind;
   regKind_t            w_rdKind;
   regKind_t            w_rdEndKind;
   logic                w_ctrlWr;
   logic                w_statusRdEnd;
   logic [CHANNELS-1:0] w_nextDir;
   logic [CHANNELS-1:0] w_dataRdEnd;
   logic [WIDTH-1:0]    w_readMux;

   assign w_wrAct = ~cs_l & ~wr_l;
   assign w_rdAct = ~cs_l & ~rd_l;

   sync_edge #(.IDLE_LEVEL(1'b0)) uWrSync (
      .clk     (clk),
      .rst_h   (rst_h),
      .i_async (w_wrAct),
      .o_rise  (w_wrRise),
      .o_fall  (w_wrFallUnused)
   );

   sync_edge #(.IDLE_LEVEL(1'b0)) uRdSync (
      .clk     (clk),
      .rst_h   (rst_h),
      .i_async (w_rdAct),
      .o_rise  (w_rdRise),
      .o_fall  (w_rdFall)
   );

   for (genvar g = 0; g < CHANNELS; g++) begin : gStb
      sync_edge #(.IDLE_LEVEL(1'b1)) uStbSync (
         .clk     (clk),
         .rst_h   (rst_h),
         .i_async (stb_l[g]),
         .o_rise  (w_stbRiseUnused[g]),
         .o_fall  (w_stbFall[g])
      );
   end

   assign w_wrKind    = decodeAddr(int'(addr), CHANNELS);
   assign w_rdKind    = decodeAddr(int'(addr), CHANNELS);
   assign w_rdEndKind = decodeAddr(int'(r_rdAddr), CHANNELS);

   assign w_ctrlWr      = w_wrRise & (w_wrKind == ACC_CTRL);
   assign w_statusRdEnd = w_rdFall & (w_rdEndKind == ACC_STATUS);

   // A CTRL write takes effect in the same cycle as a strobe, so the capture
   // decision looks at the direction the channel is about to have
   assign w_nextDir = w_ctrlWr ? din[dirLsb() +: CHANNELS] : r_dir;

   // End of a data read on an input channel, per channel, on the latched address
   always_comb begin
      w_dataRdEnd = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_dataRdEnd[i] = w_rdFall && (w_rdEndKind == ACC_DATA)
                          && (int'(r_rdAddr) == dataBase() + i) && !r_dir[i];
      end
   end

   // Register file: CPU writes, read side effects, strobe capture and overrun
   always_ff @(posedge clk) begin
      if (rst_h) begin
         r_data   <= '0;
         r_dir    <= '0;
         r_irqEn  <= '0;
         r_ibf    <= '0;
         r_ovr    <= '0;
         r_rdAddr <= '0;
      end else begin
         if (w_rdRise) begin
            r_rdAddr <= addr;
         end
         if (w_ctrlWr) begin
            r_dir   <= din[dirLsb() +: CHANNELS];
            r_irqEn <= din[irqEnLsb(CHANNELS) +: CHANNELS];
         end
         if (w_statusRdEnd) begin
            r_ovr <= '0;
         end
         for (int i = 0; i < CHANNELS; i++) begin
            if (w_wrRise && (w_wrKind == ACC_DATA) &&
                (int'(addr) == dataBase() + i) && r_dir[i]) begin
               r_data[i] <= din;
            end
            if (w_nextDir[i]) begin
               r_ibf[i] <= 1'b0;
               r_ovr[i] <= 1'b0;
            end else if (w_stbFall[i]) begin
               if (r_ibf[i] && !w_dataRdEnd[i]) begin
                  r_ovr[i] <= 1'b1;
               end else begin
                  r_data[i] <= pin_in[i*WIDTH +: WIDTH];
                  r_ibf[i]  <= 1'b1;
               end
            end else if (w_dataRdEnd[i]) begin
               r_ibf[i] <= 1'b0;
            end
         end
      end
   end

   // CPU read mux on the raw address; unselected addresses read zero
   always_comb begin
      w_readMux = '0;
      case (w_rdKind)
         ACC_DATA: begin
            for (int i = 0; i < CHANNELS; i++) begin
               if (int'(addr) == dataBase() + i) begin
                  w_readMux = r_data[i];
               end
            end
         end
         ACC_STATUS: begin
            w_readMux[ibfLsb() +: CHANNELS]         = r_ibf;
            w_readMux[ovrLsb(CHANNELS) +: CHANNELS] = r_ovr;
         end
         ACC_CTRL: begin
            w_readMux[dirLsb() +: CHANNELS]           = r_dir;
            w_readMux[irqEnLsb(CHANNELS) +: CHANNELS] = r_irqEn;
         end
         default: begin
            w_readMux = '0;
         end
      endcase
   end

   assign dout_oe_l = cs_l | rd_l;
   assign dout      = dout_oe_l ? '0 : w_readMux;
   assign pin_out   = r_data;
   assign pin_oe_l  = ~r_dir;
   assign ibf       = r_ibf;
   assign irq_l     = ~|(r_ibf & r_irqEn);

endmodule

// File: tb/tb_io_latch_bank.sv
// tb_io_latch_bank: table-driven register/pin vectors followed by hand-written
// sequences for the read/strobe collision, reset mid-write and write latency.
module tb_io_latch_bank;

   localparam int WIDTH    = 8;
   localparam int CHANNELS = 4;
   localparam int AW       = 3;

   logic                      clk = 1'b0;
   logic                      rst_h;
   logic                      cs_l, rd_l, wr_l;
   logic [AW-1:0]             addr;
   logic [WIDTH-1:0]          din;
   logic [WIDTH-1:0]          dout;
   logic                      dout_oe_l;
   logic [CHANNELS*WIDTH-1:0] pin_in;
   logic [CHANNELS*WIDTH-1:0] pin_out;
   logic [CHANNELS-1:0]       pin_oe_l;
   logic [CHANNELS-1:0]       stb_l;
   logic [CHANNELS-1:0]       ibf;
   logic                      irq_l;

   int nChecks = 0;
   int nFails  = 0;

   typedef enum {OP_WR, OP_RD, OP_STB} opKind_t;

   typedef struct {
      opKind_t     op;
      logic [2:0]  addr;
      logic [7:0]  data;
      logic [7:0]  expDout;
      logic [3:0]  expIbf;
      logic        expIrq;
      logic [3:0]  expOeL;
      logic [31:0] expPinOut;
   } vector_t;

   vector_t vecs[24];

   io_latch_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
      .clk       (clk),
      .rst_h     (rst_h),
      .cs_l      (cs_l),
      .rd_l      (rd_l),
      .wr_l      (wr_l),
      .addr      (addr),
      .din       (din),
      .dout      (dout),
      .dout_oe_l (dout_oe_l),
      .pin_in    (pin_in),
      .pin_out   (pin_out),
      .pin_oe_l  (pin_oe_l),
      .stb_l     (stb_l),
      .ibf       (ibf),
      .irq_l     (irq_l)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Compare one observed value against its expected value
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // CPU write cycle held for four clocks, then four idle clocks
   task automatic cpuWrite(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      addr = a; din = d; cs_l = 1'b0; wr_l = 1'b0;
      repeat (4) @(negedge clk);
      cs_l = 1'b1; wr_l = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // CPU read cycle; data sampled while RD is still active
   task automatic cpuRead(input logic [2:0] a, output logic [7:0] d);
      @(negedge clk);
      addr = a; cs_l = 1'b0; rd_l = 1'b0;
      repeat (3) @(negedge clk);
      d = dout;
      @(negedge clk);
      cs_l = 1'b1; rd_l = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // Peripheral strobe on one channel with its pin data
   task automatic pulseStrobe(input int ch, input logic [7:0] d);
      @(negedge clk);
      pin_in[ch*WIDTH +: WIDTH] = d;
      stb_l[ch] = 1'b0;
      repeat (3) @(negedge clk);
      stb_l[ch] = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // Perform one table operation, returning read data for RD vectors
   task automatic applyStimulus(input vector_t v, output logic [7:0] rdData);
      rdData = 8'h00;
      case (v.op)
         OP_WR:   cpuWrite(v.addr, v.data);
         OP_RD:   cpuRead(v.addr, rdData);
         default: pulseStrobe(int'(v.addr), v.data);
      endcase
   endtask

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] rd;

      // op, addr/ch, data, expDout, expIbf, expIrq, expOeL, expPinOut
      vecs[0]  = '{OP_RD,  3'd5, 8'h00, 8'h00, 4'h0, 1'b1, 4'hF, 32'h00000000};
      vecs[1]  = '{OP_RD,  3'd4, 8'h00, 8'h00, 4'h0, 1'b1, 4'hF, 32'h00000000};
      vecs[2]  = '{OP_WR,  3'd5, 8'h01, 8'h00, 4'h0, 1'b1, 4'hE, 32'h00000000};
      vecs[3]  = '{OP_WR,  3'd0, 8'hA5, 8'h00, 4'h0, 1'b1, 4'hE, 32'h000000A5};
      vecs[4]  = '{OP_RD,  3'd0, 8'h00, 8'hA5, 4'h0, 1'b1, 4'hE, 32'h000000A5};
      vecs[5]  = '{OP_WR,  3'd5, 8'h20, 8'h00, 4'h0, 1'b1, 4'hF, 32'h000000A5};
      vecs[6]  = '{OP_STB, 3'd1, 8'h3C, 8'h00, 4'h2, 1'b0, 4'hF, 32'h00003CA5};
      vecs[7]  = '{OP_RD,  3'd1, 8'h00, 8'h3C, 4'h0, 1'b1, 4'hF, 32'h00003CA5};
      vecs[8]  = '{OP_STB, 3'd2, 8'h11, 8'h00, 4'h4, 1'b1, 4'hF, 32'h00113CA5};
      vecs[9]  = '{OP_STB, 3'd2, 8'h22, 8'h00, 4'h4, 1'b1, 4'hF, 32'h00113CA5};
      vecs[10] = '{OP_RD,  3'd4, 8'h00, 8'h44, 4'h4, 1'b1, 4'hF, 32'h00113CA5};
      vecs[11] = '{OP_RD,  3'd4, 8'h00, 8'h04, 4'h4, 1'b1, 4'hF, 32'h00113CA5};
      vecs[12] = '{OP_RD,  3'd2, 8'h00, 8'h11, 4'h0, 1'b1, 4'hF, 32'h00113CA5};
      vecs[13] = '{OP_RD,  3'd7, 8'h00, 8'h00, 4'h0, 1'b1, 4'hF, 32'h00113CA5};
      vecs[14] = '{OP_WR,  3'd3, 8'h77, 8'h00, 4'h0, 1'b1, 4'hF, 32'h00113CA5};
      vecs[15] = '{OP_RD,  3'd3, 8'h00, 8'h00, 4'h0, 1'b1, 4'hF, 32'h00113CA5};
      vecs[16] = '{OP_WR,  3'd4, 8'hFF, 8'h00, 4'h0, 1'b1, 4'hF, 32'h00113CA5};
      vecs[17] = '{OP_RD,  3'd4, 8'h00, 8'h00, 4'h0, 1'b1, 4'hF, 32'h00113CA5};
      vecs[18] = '{OP_RD,  3'd5, 8'h00, 8'h20, 4'h0, 1'b1, 4'hF, 32'h00113CA5};
      vecs[19] = '{OP_WR,  3'd5, 8'h09, 8'h00, 4'h0, 1'b1, 4'h6, 32'h00113CA5};
      vecs[20] = '{OP_WR,  3'd3, 8'h5A, 8'h00, 4'h0, 1'b1, 4'h6, 32'h5A113CA5};
      vecs[21] = '{OP_STB, 3'd0, 8'hFF, 8'h00, 4'h0, 1'b1, 4'h6, 32'h5A113CA5};
      vecs[22] = '{OP_RD,  3'd5, 8'h00, 8'h09, 4'h0, 1'b1, 4'h6, 32'h5A113CA5};
      vecs[23] = '{OP_RD,  3'd6, 8'h00, 8'h00, 4'h0, 1'b1, 4'h6, 32'h5A113CA5};

      rst_h = 1'b1; cs_l = 1'b1; rd_l = 1'b1; wr_l = 1'b1;
      addr = '0; din = '0; pin_in = '0; stb_l = '1;
      repeat (3) @(negedge clk);
      rst_h = 1'b0;
      repeat (4) @(negedge clk);

      checkOutput("reset pin_oe_l", 32'(pin_oe_l), 32'hF);
      checkOutput("reset pin_out", pin_out, 32'h0);
      checkOutput("reset ibf", 32'(ibf), 32'h0);
      checkOutput("reset irq_l", 32'(irq_l), 32'h1);
      checkOutput("reset idle dout", 32'(dout), 32'h0);
      checkOutput("reset dout_oe_l", 32'(dout_oe_l), 32'h1);

      for (int i = 0; i < 24; i++) begin
         applyStimulus(vecs[i], rd);
         if (vecs[i].op == OP_RD) begin
            checkOutput($sformatf("vec%0d dout", i), 32'(rd), 32'(vecs[i].expDout));
         end
         checkOutput($sformatf("vec%0d ibf", i), 32'(ibf), 32'(vecs[i].expIbf));
         checkOutput($sformatf("vec%0d irq_l", i), 32'(irq_l), 32'(vecs[i].expIrq));
         checkOutput($sformatf("vec%0d pin_oe_l", i), 32'(pin_oe_l), 32'(vecs[i].expOeL));
         checkOutput($sformatf("vec%0d pin_out", i), pin_out, vecs[i].expPinOut);
      end

      // Collision: end of a ch0 read and a ch0 strobe land on the same cycle
      cpuWrite(3'd5, 8'h00);
      pulseStrobe(0, 8'h11);
      checkOutput("coll pre ibf", 32'(ibf), 32'h1);
      @(negedge clk);
      addr = 3'd0; cs_l = 1'b0; rd_l = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("coll read dout", 32'(dout), 32'h11);
      @(negedge clk);
      pin_in[7:0] = 8'hC3;
      cs_l = 1'b1; rd_l = 1'b1; stb_l[0] = 1'b0;
      repeat (3) @(negedge clk);
      stb_l[0] = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("coll ibf", 32'(ibf), 32'h1);
      cpuRead(3'd4, rd);
      checkOutput("coll status", 32'(rd), 32'h01);
      cpuRead(3'd0, rd);
      checkOutput("coll data", 32'(rd), 32'hC3);
      checkOutput("coll ibf cleared", 32'(ibf), 32'h0);

      // Reset asserted mid-write to CTRL and released with WR still low
      @(negedge clk);
      addr = 3'd5; din = 8'h01; cs_l = 1'b0; wr_l = 1'b0;
      @(negedge clk);
      rst_h = 1'b1;
      repeat (2) @(negedge clk);
      rst_h = 1'b0;
      repeat (5) @(negedge clk);
      cs_l = 1'b1; wr_l = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("rstwr pin_oe_l", 32'(pin_oe_l), 32'hF);
      checkOutput("rstwr pin_out", pin_out, 32'h0);
      checkOutput("rstwr irq_l", 32'(irq_l), 32'h1);
      cpuRead(3'd5, rd);
      checkOutput("rstwr ctrl", 32'(rd), 32'h00);
      cpuWrite(3'd0, 8'h99);
      cpuRead(3'd0, rd);
      checkOutput("rstwr input ch0 write ignored", 32'(rd), 32'h00);

      // Write latency: sampled at edge N, visible only after edge N+2
      @(negedge clk);
      addr = 3'd5; din = 8'h01; cs_l = 1'b0; wr_l = 1'b0;
      @(posedge clk); #1;
      checkOutput("lat N pin_oe_l", 32'(pin_oe_l), 32'hF);
      @(posedge clk); #1;
      checkOutput("lat N+1 pin_oe_l", 32'(pin_oe_l), 32'hF);
      @(posedge clk); #1;
      checkOutput("lat N+2 pin_oe_l", 32'(pin_oe_l), 32'hE);
      @(negedge clk);
      cs_l = 1'b1; wr_l = 1'b1;
      repeat (4) @(negedge clk);
      cpuRead(3'd5, rd);
      checkOutput("lat ctrl", 32'(rd), 32'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
